// File: rtl/tick_watchdog_sched.sv
// Tick spacing watchdog: validates tick intervals against a window, divides good ticks
// into scheduler events posted over req/ack, and raises sticky fault flags.
//
// state   | meaning
// S_IDLE  | waiting for the first tick, no interval checks
// S_RUN   | locked, every tick checked against the window
// S_FAULT | absorbing until rst, pending req still drains on ack
module tick_watchdog_sched #(
  parameter int unsigned PERIOD = 12501,
  parameter int unsigned MARGIN = 2,
  parameter int unsigned DIV    = 8,
  parameter int unsigned CBITS  = 15,
  parameter int unsigned EBITS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             tick_err,
  input  logic             ack,
  output logic             req,
  output logic [EBITS-1:0] ev_cnt,
  output logic             locked,
  output logic             timeout,
  output logic             early,
  output logic             upstream_fault,
  output logic             overrun
);

  localparam int unsigned TCBITS = $clog2(DIV);
  localparam logic [CBITS:0]    LO_LIM  = (CBITS+1)'(PERIOD - MARGIN);
  localparam logic [CBITS:0]    HI_LIM  = (CBITS+1)'(PERIOD + MARGIN);
  localparam logic [TCBITS-1:0] TC_LAST = TCBITS'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

  state_t             r_state, w_state_nxt;
  logic [CBITS-1:0]   r_gap, w_gap_nxt;
  logic [TCBITS-1:0]  r_tcnt, w_tcnt_nxt;
  logic               r_req, w_req_nxt;
  logic [EBITS-1:0]   r_ev_cnt, w_ev_cnt_nxt;
  logic               r_timeout, r_early, r_upstream_fault, r_overrun;
  logic               w_to_set, w_early_set, w_uf_set, w_ovr_set, w_ev;
  logic [CBITS:0]     w_interval;

  // Interval carries one extra bit so gap+1 never wraps before comparison.
  assign w_interval = {1'b0, r_gap} + (CBITS+1)'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap;
    w_tcnt_nxt   = r_tcnt;
    w_ev         = 1'b0;
    w_to_set     = 1'b0;
    w_early_set  = 1'b0;
    w_uf_set     = 1'b0;
    w_ovr_set    = 1'b0;
    w_req_nxt    = r_req;
    w_ev_cnt_nxt = r_ev_cnt;

    case (r_state)
      S_IDLE: begin
        w_gap_nxt = '0;
        if (tick) begin
          w_state_nxt = S_RUN;
          w_tcnt_nxt  = TCBITS'(1);
        end
      end
      S_RUN: begin
        w_uf_set    = tick_err;
        w_early_set = tick && (w_interval < LO_LIM);
        w_to_set    = !tick && (w_interval == HI_LIM);
        if (w_uf_set || w_early_set || w_to_set) begin
          w_state_nxt = S_FAULT;
        end else if (tick) begin
          w_gap_nxt = '0;
          if (r_tcnt == TC_LAST) begin
            w_tcnt_nxt = '0;
            w_ev       = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + TCBITS'(1);
          end
        end else if (r_gap != '1) begin
          w_gap_nxt = w_interval[CBITS-1:0];
        end
      end
      S_FAULT: begin
        w_uf_set = tick_err;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A new event retires any outstanding request in the same cycle it posts.
    if (w_ev) begin
      w_req_nxt    = 1'b1;
      w_ovr_set    = r_req && !ack;
      w_ev_cnt_nxt = r_ev_cnt + EBITS'(1);
    end else if (r_req && ack) begin
      w_req_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_gap            <= '0;
      r_tcnt           <= '0;
      r_req            <= 1'b0;
      r_ev_cnt         <= '0;
      r_timeout        <= 1'b0;
      r_early          <= 1'b0;
      r_upstream_fault <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_gap            <= w_gap_nxt;
      r_tcnt           <= w_tcnt_nxt;
      r_req            <= w_req_nxt;
      r_ev_cnt         <= w_ev_cnt_nxt;
      r_timeout        <= r_timeout | w_to_set;
      r_early          <= r_early | w_early_set;
      r_upstream_fault <= r_upstream_fault | w_uf_set;
      r_overrun        <= r_overrun | w_ovr_set;
    end
  end

  assign req            = r_req;
  assign ev_cnt         = r_ev_cnt;
  assign locked         = (r_state == S_RUN);
  assign timeout        = r_timeout;
  assign early          = r_early;
  assign upstream_fault = r_upstream_fault;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_tick_watchdog_sched.sv
// Bench for tick_watchdog_sched: cycle-stamp reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_tick_watchdog_sched;
  localparam int PERIOD = 10;
  localparam int MARGIN = 1;
  localparam int DIV    = 4;
  localparam int CBITS  = 5;
  localparam int EBITS  = 8;
  localparam int LO     = PERIOD - MARGIN;
  localparam int HI     = PERIOD + MARGIN;

  logic clk = 1'b0;
  logic rst = 1'b0, tick = 1'b0, tick_err = 1'b0, ack = 1'b0;
  logic req, locked, timeout, early, upstream_fault, overrun;
  logic [EBITS-1:0] ev_cnt;

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;
  bit  auto_ack = 1'b0;

  always #5 clk = ~clk;

  tick_watchdog_sched #(
    .PERIOD(PERIOD), .MARGIN(MARGIN), .DIV(DIV), .CBITS(CBITS), .EBITS(EBITS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .tick_err(tick_err), .ack(ack),
    .req(req), .ev_cnt(ev_cnt), .locked(locked), .timeout(timeout),
    .early(early), .upstream_fault(upstream_fault), .overrun(overrun)
  );

  // Reference model: tracks the cycle stamp of the last accepted tick and the
  // running count of good ticks; an event is every DIV-th good tick.
  bit              m_run = 0, m_fault = 0, m_req = 0;
  bit              m_to = 0, m_early = 0, m_uf = 0, m_ovr = 0;
  int              m_cyc = 0, m_last = 0, m_good = 0;
  logic [EBITS-1:0] m_ev = '0;

  always @(posedge clk) begin : model
    int d;
    bit e_s, t_s, u_s, ev;
    e_s = 0; t_s = 0; u_s = 0; ev = 0; d = 0;
    m_cyc <= m_cyc + 1;
    if (rst) begin
      m_run <= 0; m_fault <= 0; m_req <= 0; m_to <= 0; m_early <= 0;
      m_uf <= 0; m_ovr <= 0; m_good <= 0; m_ev <= '0;
    end else begin
      if (m_run) begin
        d   = m_cyc - m_last;
        e_s = tick && (d < LO);
        t_s = !tick && (d == HI);
        u_s = tick_err;
        if (e_s || t_s || u_s) begin
          m_run <= 0; m_fault <= 1;
        end else if (tick) begin
          m_last <= m_cyc;
          m_good <= m_good + 1;
          ev = ((m_good + 1) % DIV) == 0;
        end
      end else if (m_fault) begin
        u_s = tick_err;
      end else if (tick) begin
        m_run <= 1; m_last <= m_cyc; m_good <= 1;
      end
      if (e_s) m_early <= 1;
      if (t_s) m_to <= 1;
      if (u_s) m_uf <= 1;
      if (ev) begin
        m_ev  <= m_ev + EBITS'(1);
        m_req <= 1;
        if (m_req && !ack) m_ovr <= 1;
      end else if (m_req && ack) begin
        m_req <= 0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_req", {31'd0, req}, {31'd0, m_req});
      cmp("m_ev_cnt", {24'd0, ev_cnt}, {24'd0, m_ev});
      cmp("m_locked", {31'd0, locked}, {31'd0, m_run});
      cmp("m_timeout", {31'd0, timeout}, {31'd0, m_to});
      cmp("m_early", {31'd0, early}, {31'd0, m_early});
      cmp("m_upstream_fault", {31'd0, upstream_fault}, {31'd0, m_uf});
      cmp("m_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    end
  end

  // Drive one cycle of inputs (called just after a falling edge) and advance
  // to the next falling edge, where that cycle's results are visible.
  task automatic step(input bit t, input bit e, input bit a);
    tick = t; tick_err = e; ack = a;
    @(negedge clk);
  endtask

  task automatic tk(input bit t, input bit e);
    step(t, e, auto_ack && (req === 1'b1));
  endtask

  task automatic interval(input int k);
    repeat (k - 1) tk(0, 0);
    tk(1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin : stim
    int cnt, tgt, k;
    bit t;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    cmp("reset_outputs", {20'd0, req, ev_cnt, locked, timeout, early, upstream_fault, overrun}, 0);

    // Nominal lock at exact period with prompt ack.
    auto_ack = 1'b1;
    tk(1, 0);
    cmp("t1_locked", locked, 1);
    repeat (11) interval(PERIOD);
    cmp("t1_ev_cnt", ev_cnt, 3);
    cmp("t1_flags", {timeout, early, upstream_fault, overrun}, 0);

    // Window edges are good.
    interval(LO); interval(HI); interval(PERIOD);
    cmp("t2_flags", {timeout, early, upstream_fault, overrun}, 0);
    cmp("t2_locked", locked, 1);
    cmp("t2_ev_cnt", ev_cnt, 3);

    // Early tick faults, further ticks are ignored.
    interval(LO - 1);
    cmp("t3_early", early, 1);
    cmp("t3_locked", locked, 0);
    repeat (5) interval(PERIOD);
    cmp("t3_ev_frozen", ev_cnt, 3);

    // Missing tick raises timeout 11 edges after the last tick.
    do_reset();
    tk(1, 0);
    repeat (HI - 1) tk(0, 0);
    cmp("t4_no_timeout_yet", timeout, 0);
    tk(0, 0);
    cmp("t4_timeout", timeout, 1);
    cmp("t4_unlocked", locked, 0);
    do_reset();
    tk(1, 0);
    interval(HI);
    cmp("t4_hi_edge_no_timeout", timeout, 0);
    cmp("t4_hi_edge_locked", locked, 1);
    interval(HI);
    cmp("t4_hi_edge_again", {timeout, locked}, 2'b01);

    // No ack: overrun, then ack coinciding with a new event.
    do_reset();
    auto_ack = 1'b0;
    tk(1, 0);
    repeat (3) interval(PERIOD);
    cmp("t5_req_first", {req, overrun}, 2'b10);
    repeat (4) interval(PERIOD);
    cmp("t5_overrun", overrun, 1);
    repeat (4) interval(PERIOD);
    cmp("t5_ev_cnt3", ev_cnt, 3);
    cmp("t5_req_held", req, 1);
    repeat (3) interval(PERIOD);
    repeat (PERIOD - 1) tk(0, 0);
    step(1, 0, 1);
    cmp("t5_req_reposted", req, 1);
    cmp("t5_ev_cnt4", ev_cnt, 4);

    // tick_err on the wrapping tick, then reset and relock.
    do_reset();
    tk(1, 0);
    repeat (2) interval(PERIOD);
    repeat (PERIOD - 1) tk(0, 0);
    tk(1, 1);
    cmp("t6_uf", upstream_fault, 1);
    cmp("t6_no_event", {req, ev_cnt}, 0);
    cmp("t6_unlocked", locked, 0);
    do_reset();
    cmp("t6_reset_outputs", {20'd0, req, ev_cnt, locked, timeout, early, upstream_fault, overrun}, 0);
    tk(1, 0);
    cmp("t6_relock", locked, 1);

    // Early and tick_err together set both flags.
    do_reset();
    tk(1, 0);
    repeat (LO - 2) tk(0, 0);
    tk(1, 1);
    cmp("early_and_err", {early, upstream_fault, timeout}, 3'b110);

    // Long good run wraps ev_cnt: 1100 ticks -> 275 events -> 19 mod 256.
    do_reset();
    tk(1, 0);
    repeat (1099) begin
      k = $urandom_range(LO, HI);
      repeat (k - 1) step(0, 0, 1'($urandom_range(0, 1)));
      step(1, 0, 1'($urandom_range(0, 1)));
    end
    cmp("wrap_ev_cnt", ev_cnt, 19);
    cmp("wrap_no_faults", {timeout, early, upstream_fault}, 0);

    // Randomized traffic including bad intervals, errors and stray resets.
    repeat (20) begin
      do_reset();
      cnt = 0;
      tgt = $urandom_range(1, HI);
      repeat (400) begin
        cnt++;
        t = (cnt >= tgt);
        if (t) begin
          cnt = 0;
          tgt = $urandom_range(LO - 2, HI + 1);
        end
        rst = ($urandom_range(0, 999) == 0);
        step(t, $urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));
        rst = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_watchdog_sched.md
Name: tick_watchdog_sched

Overview:
- Sits directly downstream of the periodic delay/tick generator.
- Consumes its one-cycle tick pulse and its error flag.
- Checks the tick spacing against a tolerance window and divides ticks into scheduler events.
- Presents each event to the next stage through a req/ack handshake and raises sticky fault flags to the system monitor.

Parameters:
- PERIOD, 12501: expected cycles between consecutive ticks (tick-to-tick distance).
- MARGIN, 2: allowed deviation in cycles, either side of PERIOD.
- DIV, 8: ticks per scheduler event, must be >= 2.
- CBITS, 15: gap counter width; must satisfy 2^CBITS - 1 >= PERIOD + MARGIN.
- EBITS, 8: event counter width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse from the upstream tick generator.
- tick_err  in  1  upstream error flag; level, sampled every cycle.
- ack  in  1  consumer acknowledge for req.
- req  out  1  event pending; held until acked.
- ev_cnt  out  EBITS  number of events generated, modulo 2^EBITS.
- locked  out  1  high while state == RUN.
- timeout  out  1  sticky: tick missing past the window.
- early  out  1  sticky: tick arrived before the window.
- upstream_fault  out  1  sticky: tick_err seen while not IDLE.
- overrun  out  1  sticky: an event was generated while req was still pending.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, gap=0, tcnt=0. Outputs req=0, ev_cnt=0, locked=0, timeout=0, early=0, upstream_fault=0, overrun=0. Reset overrides every other input in the same cycle, including mid-handshake.
- State machine, three states: IDLE, RUN, FAULT.
- IDLE:
  - No checks are performed; gap is held at 0.
  - First tick: go to RUN, gap <= 0, tcnt <= 1. This tick counts toward DIV but is not interval-checked.
- RUN:
  - tick=0: gap <= gap+1, saturating at 2^CBITS-1.
  - tick=1: interval = gap+1. If interval < PERIOD-MARGIN, set early and go to FAULT. Otherwise the tick is good: gap <= 0, tcnt advances.
  - Timeout: if tick=0 and gap+1 == PERIOD+MARGIN, set timeout and go to FAULT. The flag is visible the cycle after that edge.
  - Window rule: a tick with interval in [PERIOD-MARGIN, PERIOD+MARGIN] is good. A tick arriving on the same cycle as the timeout condition is good; no timeout is raised.
  - tick_err=1 in RUN: set upstream_fault and go to FAULT. It takes priority over a simultaneous good tick; that tick is not counted.
- FAULT:
  - Absorbing until rst. No tick counting and no new events.
  - tick_err still sets upstream_fault.
  - A pending req still completes normally on ack.
- Tick division:
  - tcnt counts good ticks modulo DIV.
  - When a good tick makes tcnt wrap from DIV-1 to 0, an event is generated: ev_cnt <= ev_cnt+1, wrapping at 2^EBITS.
- Handshake:
  - req rises the cycle after the edge on which the event is generated.
  - A cycle with req=1 and ack=1 clears req on the next edge. ack while req=0 is ignored.
  - Event and ack in the same cycle with req=1: req stays 1 (old request retired, new one posted); no overrun.
  - Event with req=1 and ack=0: overrun is set, req stays 1, ev_cnt still increments. Events never queue beyond one.
- Flag priority and latency:
  - Fault flags are set-only until rst; all outputs are registered.
  - If early and tick_err occur together, both flags are set.
  - Latency from tick to req is one cycle.

Test Plan:
Use PERIOD=10, MARGIN=1, DIV=4, EBITS=8 unless noted.
1. Ticks every 10 cycles, ack the cycle after each req -> locked=1 from the cycle after the first tick; req pulses after the 4th, 8th and 12th ticks; ev_cnt=3; all fault flags 0.
2. Ticks at intervals 9, 11, 10 (window edges) -> no flags set; locked stays 1.
3. After lock, a tick at interval 8 -> early=1 and locked=0 the next cycle; further ticks leave ev_cnt unchanged.
4. After lock, ticks stop -> timeout=1 on the cycle after gap reaches 10 (11 cycles after the last tick); with ticks resumed, a tick at interval exactly 11 instead gives no timeout.
5. Never ack, 12 good ticks -> req=1 from the 4th tick; overrun=1 after the 8th tick; ev_cnt=3; then ack coinciding with the 16th tick -> req remains 1 and ev_cnt=4.
6. tick_err pulse together with a wrapping tick -> upstream_fault=1, no event, state FAULT; then rst=1 for one cycle -> all outputs 0 and state IDLE; the next tick relocks.
